// File: rtl/decoder_scan_nx.sv
// Registered N-to-M binary-to-one-hot decoder with a free-running SCAN mode.
// Optional range checking (err port) is enabled by defining DEC_RANGE_CHK_EN.
module decoder_scan_nx #(
  parameter int IN_W       = 3,
  parameter int OUT_N      = 8,
  parameter int DWELL_W    = 8,
  parameter int ACTIVE_LOW = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic [IN_W-1:0]    data_in,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_N-1:0]   result,
  output logic               out_valid,
  output logic               scan_wrap
`ifdef DEC_RANGE_CHK_EN
  ,
  output logic               err
`endif
);

  typedef enum logic [1:0] {IDLE, DECODE, SCAN} state_t;

  localparam logic [OUT_N-1:0] INACTIVE = {OUT_N{ACTIVE_LOW != 0}};
  localparam logic [IN_W-1:0]  LAST_IDX = IN_W'(OUT_N - 1);

  state_t             state, state_nx;
  logic [IN_W-1:0]    idx, idx_nx, idx_inc;
  logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_nx;
  logic [OUT_N-1:0]   result_nx;
  logic               out_valid_nx, scan_wrap_nx;
`ifdef DEC_RANGE_CHK_EN
  logic               err_nx;
`endif

  // Out-of-range codes match no line, so they naturally decode to INACTIVE.
  function automatic logic [OUT_N-1:0] drive_line(input logic [IN_W-1:0] code);
    logic [OUT_N-1:0] sel;
    sel = '0;
    for (int i = 0; i < OUT_N; i++) sel[i] = (code == IN_W'(i));
    return sel ^ INACTIVE;
  endfunction

  assign in_ready = (state == DECODE);
  assign idx_inc  = (idx == LAST_IDX) ? '0 : idx + 1'b1;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_nx     = !en ? IDLE : (mode ? SCAN : DECODE);
    idx_nx       = idx;
    dwell_cnt_nx = dwell_cnt;
    result_nx    = result;
    out_valid_nx = 1'b0;
    scan_wrap_nx = 1'b0;
`ifdef DEC_RANGE_CHK_EN
    err_nx       = 1'b0;
`endif
    case (state_nx)
      DECODE: begin
        if (state != DECODE) begin
          result_nx = INACTIVE;
        end else if (in_valid) begin
          result_nx    = drive_line(data_in);
          out_valid_nx = 1'b1;
`ifdef DEC_RANGE_CHK_EN
          err_nx       = ({1'b0, data_in} >= (IN_W+1)'(OUT_N));
`endif
        end
      end
      SCAN: begin
        if (state != SCAN) begin
          idx_nx       = '0;
          dwell_cnt_nx = '0;
          result_nx    = drive_line('0);
          out_valid_nx = 1'b1;
        end else if (dwell_cnt >= dwell) begin
          // A count already past a freshly lowered dwell advances at once.
          idx_nx       = idx_inc;
          dwell_cnt_nx = '0;
          result_nx    = drive_line(idx_inc);
          out_valid_nx = 1'b1;
          scan_wrap_nx = (idx == LAST_IDX);
        end else begin
          dwell_cnt_nx = dwell_cnt + 1'b1;
        end
      end
      default: begin
        idx_nx       = '0;
        dwell_cnt_nx = '0;
        result_nx    = INACTIVE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      dwell_cnt <= '0;
      result    <= INACTIVE;
      out_valid <= 1'b0;
      scan_wrap <= 1'b0;
`ifdef DEC_RANGE_CHK_EN
      err       <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      dwell_cnt <= dwell_cnt_nx;
      result    <= result_nx;
      out_valid <= out_valid_nx;
      scan_wrap <= scan_wrap_nx;
`ifdef DEC_RANGE_CHK_EN
      err       <= err_nx;
`endif
    end
  end

endmodule

// File: tb/tb_decoder_scan_nx.sv
// Directed bench for decoder_scan_nx: four parameter sets share one stimulus
// stream (8 lines, 6 lines, 4 lines, 8 lines active-low).
module tb_decoder_scan_nx;

  logic       clk = 1'b0;
  logic       rst_n, en, mode, in_valid;
  logic [2:0] data_in;
  logic [7:0] dwell;

  logic [7:0] res8, res_al;
  logic [5:0] res6;
  logic [3:0] res4;
  logic rdy8, rdy6, rdy4, rdy_al;
  logic ov8, ov6, ov4, ov_al;
  logic wr8, wr6, wr4, wr_al;
`ifdef DEC_RANGE_CHK_EN
  logic err8, err6, err4, err_al;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decoder_scan_nx #(.IN_W(3), .OUT_N(8), .DWELL_W(8), .ACTIVE_LOW(0)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .data_in(data_in),
    .in_valid(in_valid), .in_ready(rdy8), .dwell(dwell), .result(res8),
    .out_valid(ov8), .scan_wrap(wr8)
`ifdef DEC_RANGE_CHK_EN
    , .err(err8)
`endif
  );

  decoder_scan_nx #(.IN_W(3), .OUT_N(6), .DWELL_W(8), .ACTIVE_LOW(0)) dut6 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .data_in(data_in),
    .in_valid(in_valid), .in_ready(rdy6), .dwell(dwell), .result(res6),
    .out_valid(ov6), .scan_wrap(wr6)
`ifdef DEC_RANGE_CHK_EN
    , .err(err6)
`endif
  );

  decoder_scan_nx #(.IN_W(3), .OUT_N(4), .DWELL_W(8), .ACTIVE_LOW(0)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .data_in(data_in),
    .in_valid(in_valid), .in_ready(rdy4), .dwell(dwell), .result(res4),
    .out_valid(ov4), .scan_wrap(wr4)
`ifdef DEC_RANGE_CHK_EN
    , .err(err4)
`endif
  );

  decoder_scan_nx #(.IN_W(3), .OUT_N(8), .DWELL_W(8), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .data_in(data_in),
    .in_valid(in_valid), .in_ready(rdy_al), .dwell(dwell), .result(res_al),
    .out_valid(ov_al), .scan_wrap(wr_al)
`ifdef DEC_RANGE_CHK_EN
    , .err(err_al)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then read 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; in_valid = 1'b0;
    data_in = '0; dwell = '0;
    step(); step();
    check("reset_res8", res8, 8'h00);
    check("reset_ov8", ov8, 1'b0);
    check("reset_rdy8", rdy8, 1'b0);
    check("reset_res_al", res_al, 8'hFF);
    check("reset_wrap4", wr4, 1'b0);

    rst_n = 1'b1; en = 1'b1; mode = 1'b0;
    step();
    check("dec_entry_rdy", rdy8, 1'b1);
    check("dec_entry_res", res8, 8'h00);
    check("dec_entry_ov", ov8, 1'b0);

    // Back-to-back accepts 0..7, one-clock latency
    for (int i = 0; i < 8; i++) begin
      data_in = 3'(i); in_valid = 1'b1;
      step();
      check("b2b_res8", res8, 32'h1 << i);
      check("b2b_ov8", ov8, 1'b1);
      if (i == 2) check("al_res_code2", res_al, 8'hFB);
      if (i == 5) check("n6_res_code5", res6, 6'h20);
      if (i == 6) begin
        check("n6_res_code6", res6, 6'h00);
        check("n6_ov_code6", ov6, 1'b1);
      end
      if (i == 7) check("n4_res_code7", res4, 4'h0);
`ifdef DEC_RANGE_CHK_EN
      if (i == 5) check("n6_err_code5", err6, 1'b0);
      if (i == 6) check("n6_err_code6", err6, 1'b1);
`endif
    end
    in_valid = 1'b0;
    step();
    check("hold_res8", res8, 8'h80);
    check("hold_ov8", ov8, 1'b0);

    en = 1'b0;
    step();
    check("idle_res_al", res_al, 8'hFF);
    check("idle_res8", res8, 8'h00);
    check("idle_rdy8", rdy8, 1'b0);

    // SCAN, dwell=2, 4 lines: 1,2,4,8,1 every 3 clocks
    en = 1'b1; mode = 1'b1; dwell = 8'd2; data_in = 3'd1; in_valid = 1'b1;
    step();
    check("scan_entry_res4", res4, 4'h1);
    check("scan_entry_ov4", ov4, 1'b1);
    check("scan_rdy4", rdy4, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      step();
      check("scan_res4", res4, 32'h1 << ((k / 3) % 4));
      check("scan_ov4", ov4, ((k % 3) == 0) ? 1'b1 : 1'b0);
      check("scan_wrap4", wr4, (k == 12) ? 1'b1 : 1'b0);
    end

    // dwell=0 advances every clock; then back to DECODE
    dwell = 8'd0;
    step();
    check("dw0_res4_a", res4, 4'h2);
    step();
    check("dw0_res4_b", res4, 4'h4);
    check("dw0_ov4", ov4, 1'b1);
    mode = 1'b0; in_valid = 1'b0;
    step();
    check("sw_dec_res4", res4, 4'h0);
    check("sw_dec_rdy4", rdy4, 1'b1);
    check("sw_dec_ov4", ov4, 1'b0);

    // Reset mid-scan at idx=3, restart at line 0
    mode = 1'b1;
    step();
    check("rs_entry_res4", res4, 4'h1);
    step(); step();
    step();
    check("rs_idx3_res4", res4, 4'h8);
    rst_n = 1'b0;
    step();
    check("rs_res4", res4, 4'h0);
    check("rs_ov4", ov4, 1'b0);
    check("rs_wrap4", wr4, 1'b0);
    rst_n = 1'b1;
    step();
    check("rs_restart_res4", res4, 4'h1);
    check("rs_restart_ov4", ov4, 1'b1);

    // Lowering dwell below the running count advances on the next edge
    dwell = 8'd3;
    step(); step();
    check("dwchg_hold_res4", res4, 4'h1);
    check("dwchg_hold_ov4", ov4, 1'b0);
    dwell = 8'd1;
    step();
    check("dwchg_adv_res4", res4, 4'h2);
    check("dwchg_adv_ov4", ov4, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
